sr_flag_arbiter: RTL and testbench

Shared controller for a bank of clocked SR flag flip-flops. Up to NREQ requesters issue set/clear masks over a four-phase req/gnt handshake; the block arbitrates round-robin, applies exactly one winner's masks per grant, and resolves forbidden S=R=1 bits before they reach the flags. It sits between software-visible request agents and the SR flag storage, sequencing all writes so the forbidden latch input combination never occurs.

---
 rtl/sr_flag_arb_pkg.sv | 25 ++
 rtl/rr_pick.sv | 51 +++++
 rtl/sr_flag_arbiter.sv | 165 ++++++++++++++++
 tb/tb_sr_flag_arbiter.sv | 206 ++++++++++++++++++++
 4 files changed

// File: rtl/sr_flag_arb_pkg.sv
// sr_flag_arb_pkg: shared types and constants for the SR flag arbiter.
//   state_t   : arbiter FSM states (IDLE, GRANT, HOLD)
//   DEF_NREQ  : default requester count
//   DEF_NFLAG : default flag count
//   idx_width : bit width needed to index NREQ requesters (minimum 1)
package sr_flag_arb_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GRANT = 2'd1,
    HOLD  = 2'd2
  } state_t;

  localparam int DEF_NREQ  = 4;
  localparam int DEF_NFLAG = 8;

  function automatic int idx_width(input int n);
    if (n <= 2) begin
      return 1;
    end else begin
      return $clog2(n);
    end
  endfunction

endpackage

// File: rtl/rr_pick.sv
// rr_pick: combinational rotating-priority encoder.
// Picks the first asserted request at or after index ptr, wrapping modulo NREQ.
// Ports:
//   req    [NREQ-1:0] in  : request vector
//   ptr    [IW-1:0]   in  : highest-priority index (must be < NREQ)
//   onehot [NREQ-1:0] out : one-hot winner
//   idx    [IW-1:0]   out : winner index
//   valid             out : at least one request asserted
module rr_pick
  import sr_flag_arb_pkg::*;
#(
  parameter int NREQ = DEF_NREQ,
  parameter int IW   = idx_width(NREQ)
) (
  input  logic [NREQ-1:0] req,
  input  logic [IW-1:0]   ptr,
  output logic [NREQ-1:0] onehot,
  output logic [IW-1:0]   idx,
  output logic            valid
);

  // One spare bit so ptr + k can exceed NREQ-1 before wrapping.
  logic [IW:0]   sum;
  logic [IW-1:0] cand;

  // Scan candidates ptr, ptr+1, ... (mod NREQ) and keep the first requester.
  always_comb begin
    onehot = {NREQ{1'b0}};
    idx    = {IW{1'b0}};
    valid  = 1'b0;
    sum    = {(IW+1){1'b0}};
    cand   = {IW{1'b0}};
    for (int k = 0; k < NREQ; k++) begin
      sum = {1'b0, ptr} + (IW+1)'(k);
      if (sum >= (IW+1)'(NREQ)) begin
        sum = sum - (IW+1)'(NREQ);
      end else begin
        sum = sum;
      end
      cand = sum[IW-1:0];
      if (!valid && req[cand]) begin
        valid        = 1'b1;
        onehot[cand] = 1'b1;
        idx          = cand;
      end else begin
        valid = valid;
      end
    end
  end

endmodule

// File: rtl/sr_flag_arbiter.sv
// sr_flag_arbiter: round-robin arbiter sequencing set/clear masks from NREQ
// requesters into a bank of NFLAG SR flags over a four-phase req/gnt handshake.
// Ports:
//   clk                  in  : rising-edge clock
//   rst                  in  : asynchronous active-high reset
//   req   [NREQ-1:0]       in  : per-requester request (held until gnt seen)
//   S     [NREQ*NFLAG-1:0] in  : set masks, requester i at [i*NFLAG +: NFLAG]
//   R     [NREQ*NFLAG-1:0] in  : reset masks, same packing as S
//   gnt   [NREQ-1:0]       out : one-hot grant (GRANT and HOLD states)
//   Q     [NFLAG-1:0]      out : flag state
//   Qn    [NFLAG-1:0]      out : inverse of Q
//   conflict             out : one-cycle pulse when the winner had S=R=1 bits
//   busy                 out : high whenever the FSM is not IDLE
// Build option SR_FLAG_ARB_CONFLICT_CHECK_EN: when defined, S=R=1 bits hold
// their previous value and raise conflict; otherwise R dominates and
// conflict stays 0.
module sr_flag_arbiter
  import sr_flag_arb_pkg::*;
#(
  parameter int NREQ  = DEF_NREQ,
  parameter int NFLAG = DEF_NFLAG
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [NREQ-1:0]        req,
  input  logic [NREQ*NFLAG-1:0]  S,
  input  logic [NREQ*NFLAG-1:0]  R,
  output logic [NREQ-1:0]        gnt,
  output logic [NFLAG-1:0]       Q,
  output logic [NFLAG-1:0]       Qn,
  output logic                   conflict,
  output logic                   busy
);

  localparam int IW = idx_width(NREQ);

  state_t            state_r, state_s;
  logic [IW-1:0]     ptr_r, ptr_s;
  logic [IW-1:0]     win_r, win_s;
  logic [NREQ-1:0]   gnt_r, gnt_s;
  logic [NFLAG-1:0]  q_r, q_s;
  logic              conflict_r, conflict_s;
  logic              busy_r;

  logic [NREQ-1:0]   pick_onehot_s;
  logic [IW-1:0]     pick_idx_s;
  logic              pick_valid_s;
  logic [NFLAG-1:0]  s_win_s, r_win_s;
  logic [NFLAG-1:0]  q_apply_s;
  logic              conflict_hit_s;
  logic              hold_req_s;

  rr_pick #(
    .NREQ (NREQ),
    .IW   (IW)
  ) u_pick (
    .req    (req),
    .ptr    (ptr_r),
    .onehot (pick_onehot_s),
    .idx    (pick_idx_s),
    .valid  (pick_valid_s)
  );

  // The granted requester's own req bit; gnt_r is one-hot while in HOLD.
  assign hold_req_s = |(req & gnt_r);

  // Select the winner's mask slices; non-winner masks never reach the flags.
  always_comb begin
    s_win_s = {NFLAG{1'b0}};
    r_win_s = {NFLAG{1'b0}};
    for (int i = 0; i < NREQ; i++) begin
      if (win_r == IW'(i)) begin
        s_win_s = S[i*NFLAG +: NFLAG];
        r_win_s = R[i*NFLAG +: NFLAG];
      end else begin
        s_win_s = s_win_s;
      end
    end
  end

  // Per-bit SR resolution of the winner's masks against the current flags.
  always_comb begin
`ifdef SR_FLAG_ARB_CONFLICT_CHECK_EN
    // Bits with S==R (both 0 or both 1) keep their value; S=1,R=0 sets.
    q_apply_s      = (q_r & ~(s_win_s ^ r_win_s)) | (s_win_s & ~r_win_s);
    conflict_hit_s = |(s_win_s & r_win_s);
`else
    // Clear wins over set.
    q_apply_s      = (q_r | s_win_s) & ~r_win_s;
    conflict_hit_s = 1'b0;
`endif
  end

  // FSM next-state, grant, pointer and flag-update logic.
  always_comb begin
    state_s    = state_r;
    ptr_s      = ptr_r;
    win_s      = win_r;
    gnt_s      = gnt_r;
    q_s        = q_r;
    conflict_s = 1'b0;
    case (state_r)
      IDLE: begin
        if (pick_valid_s) begin
          state_s = GRANT;
          win_s   = pick_idx_s;
          gnt_s   = pick_onehot_s;
        end else begin
          gnt_s = {NREQ{1'b0}};
        end
      end
      GRANT: begin
        // Masks are applied even if the winner already dropped req.
        state_s    = HOLD;
        q_s        = q_apply_s;
        conflict_s = conflict_hit_s;
        if (win_r == IW'(NREQ-1)) begin
          ptr_s = {IW{1'b0}};
        end else begin
          ptr_s = win_r + IW'(1'b1);
        end
      end
      HOLD: begin
        if (!hold_req_s) begin
          state_s = IDLE;
          gnt_s   = {NREQ{1'b0}};
        end else begin
          state_s = HOLD;
        end
      end
      default: begin
        state_s = IDLE;
        gnt_s   = {NREQ{1'b0}};
      end
    endcase
  end

  // State and output registers with asynchronous reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r    <= IDLE;
      ptr_r      <= {IW{1'b0}};
      win_r      <= {IW{1'b0}};
      gnt_r      <= {NREQ{1'b0}};
      q_r        <= {NFLAG{1'b0}};
      conflict_r <= 1'b0;
      busy_r     <= 1'b0;
    end else begin
      state_r    <= state_s;
      ptr_r      <= ptr_s;
      win_r      <= win_s;
      gnt_r      <= gnt_s;
      q_r        <= q_s;
      conflict_r <= conflict_s;
      busy_r     <= (state_s != IDLE);
    end
  end

  assign gnt      = gnt_r;
  assign Q        = q_r;
  assign Qn       = ~q_r;
  assign conflict = conflict_r;
  assign busy     = busy_r;

endmodule

// File: tb/tb_sr_flag_arbiter.sv
// tb_sr_flag_arbiter: directed self-checking bench for sr_flag_arbiter
// (NREQ=4, NFLAG=8). Inputs change and outputs are sampled on the falling edge.
module tb_sr_flag_arbiter;

  localparam int NREQ  = 4;
  localparam int NFLAG = 8;

`ifdef SR_FLAG_ARB_CONFLICT_CHECK_EN
  localparam logic [7:0] EXP_CONF_Q = 8'h81;
  localparam logic       EXP_CONF   = 1'b1;
`else
  localparam logic [7:0] EXP_CONF_Q = 8'h01;
  localparam logic       EXP_CONF   = 1'b0;
`endif

  logic                  clk = 1'b0;
  logic                  rst;
  logic [NREQ-1:0]       req;
  logic [NREQ*NFLAG-1:0] S, R;
  logic [NREQ-1:0]       gnt;
  logic [NFLAG-1:0]      Q, Qn;
  logic                  conflict, busy;

  int checks = 0;
  int errors = 0;

  sr_flag_arbiter #(.NREQ(NREQ), .NFLAG(NFLAG)) dut (
    .clk(clk), .rst(rst), .req(req), .S(S), .R(R),
    .gnt(gnt), .Q(Q), .Qn(Qn), .conflict(conflict), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic set_masks(input int idx, input logic [7:0] s, input logic [7:0] r);
    S[idx*NFLAG +: NFLAG] = s;
    R[idx*NFLAG +: NFLAG] = r;
  endtask

  task automatic pulse_reset();
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
  endtask

  // Waits (bounded) for a grant, records gnt, Q and conflict in the HOLD
  // cycle, releases the granted req and returns once back in IDLE.
  task automatic serve(output logic [3:0] g, output logic [7:0] qh,
                       output logic ch, output bit ok);
    ok = 1'b0; g = 4'h0; qh = 8'h00; ch = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (gnt !== 4'h0) break;
      @(negedge clk);
    end
    if (gnt !== 4'h0) begin
      ok = 1'b1;
      g  = gnt;
      @(negedge clk);
      qh  = Q;
      ch  = conflict;
      req = req & ~g;
      @(negedge clk);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; req = 4'h0; S = '0; R = '0;
    repeat (2) @(negedge clk);
    checks++; if (Q !== 8'h00) begin errors++; $display("FAIL reset_q got %h exp 00", Q); end
    checks++; if (Qn !== 8'hFF) begin errors++; $display("FAIL reset_qn got %h exp ff", Qn); end
    checks++; if (gnt !== 4'h0) begin errors++; $display("FAIL reset_gnt got %b exp 0000", gnt); end
    checks++; if (busy !== 1'b0 || conflict !== 1'b0) begin errors++; $display("FAIL reset_busy_conf got %b%b exp 00", busy, conflict); end
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_single();
    logic [3:0] g; logic [7:0] qh; logic ch; bit ok;
    set_masks(0, 8'h0F, 8'h00);
    req = 4'b0001;
    @(negedge clk);
    checks++; if (gnt !== 4'b0001 || busy !== 1'b1) begin errors++; $display("FAIL single_grant got gnt=%b busy=%b exp 0001 1", gnt, busy); end
    checks++; if (Q !== 8'h00) begin errors++; $display("FAIL single_q_early got %h exp 00", Q); end
    @(negedge clk);
    checks++; if (Q !== 8'h0F || Qn !== 8'hF0) begin errors++; $display("FAIL single_q got %h/%h exp 0f/f0", Q, Qn); end
    checks++; if (gnt !== 4'b0001) begin errors++; $display("FAIL single_hold_gnt got %b exp 0001", gnt); end
    req = 4'b0000;
    @(negedge clk);
    checks++; if (gnt !== 4'h0 || busy !== 1'b0) begin errors++; $display("FAIL single_release got gnt=%b busy=%b exp 0000 0", gnt, busy); end
    set_masks(0, 8'h00, 8'h03);
    req = 4'b0001;
    serve(g, qh, ch, ok);
    checks++; if (ok !== 1'b1 || g !== 4'b0001) begin errors++; $display("FAIL single_clear_gnt got %b ok=%0d exp 0001", g, ok); end
    checks++; if (qh !== 8'h0C) begin errors++; $display("FAIL single_clear_q got %h exp 0c", qh); end
  endtask

  task automatic test_round_robin();
    logic [3:0] g; logic [7:0] qh; logic ch; bit ok;
    logic [3:0] exp_g [4] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000};
    logic [7:0] exp_q [4] = '{8'h01, 8'h03, 8'h07, 8'h0F};
    pulse_reset();
    for (int i = 0; i < NREQ; i++) set_masks(i, 8'h01 << i, 8'h00);
    req = 4'b1111;
    for (int i = 0; i < 4; i++) begin
      serve(g, qh, ch, ok);
      checks++; if (ok !== 1'b1 || g !== exp_g[i]) begin errors++; $display("FAIL rr_order[%0d] got %b exp %b", i, g, exp_g[i]); end
      checks++; if (qh !== exp_q[i]) begin errors++; $display("FAIL rr_q[%0d] got %h exp %h", i, qh, exp_q[i]); end
    end
    // Requester 2 re-requests right after its grant: 3 must be served first.
    pulse_reset();
    req = 4'b1111;
    for (int i = 0; i < 3; i++) serve(g, qh, ch, ok);
    checks++; if (g !== 4'b0100) begin errors++; $display("FAIL rr_third got %b exp 0100", g); end
    req[2] = 1'b1;
    serve(g, qh, ch, ok);
    checks++; if (ok !== 1'b1 || g !== 4'b1000) begin errors++; $display("FAIL rr_rereq_3first got %b exp 1000", g); end
    serve(g, qh, ch, ok);
    checks++; if (ok !== 1'b1 || g !== 4'b0100) begin errors++; $display("FAIL rr_rereq_2after got %b exp 0100", g); end
  endtask

  task automatic test_ptr_wrap();
    logic [3:0] g; logic [7:0] qh; logic ch; bit ok;
    req = 4'b1000;
    serve(g, qh, ch, ok);
    checks++; if (ok !== 1'b1 || g !== 4'b1000) begin errors++; $display("FAIL wrap_last3 got %b exp 1000", g); end
    req = 4'b1001;
    serve(g, qh, ch, ok);
    checks++; if (ok !== 1'b1 || g !== 4'b0001) begin errors++; $display("FAIL wrap_zero_wins got %b exp 0001", g); end
    serve(g, qh, ch, ok);
    checks++; if (ok !== 1'b1 || g !== 4'b1000) begin errors++; $display("FAIL wrap_then3 got %b exp 1000", g); end
  endtask

  task automatic test_conflict();
    logic [3:0] g; logic [7:0] qh; logic ch; bit ok;
    pulse_reset();
    set_masks(1, 8'hFF, 8'h00);   // idle requester's masks must be ignored
    set_masks(0, 8'h80, 8'h00);
    req = 4'b0001;
    serve(g, qh, ch, ok);
    checks++; if (ok !== 1'b1 || qh !== 8'h80 || ch !== 1'b0) begin errors++; $display("FAIL conf_pre got q=%h c=%b exp 80 0", qh, ch); end
    set_masks(0, 8'h81, 8'h80);
    req = 4'b0001;
    serve(g, qh, ch, ok);
    checks++; if (qh !== EXP_CONF_Q) begin errors++; $display("FAIL conf_q got %h exp %h", qh, EXP_CONF_Q); end
    checks++; if (ch !== EXP_CONF) begin errors++; $display("FAIL conf_pulse got %b exp %b", ch, EXP_CONF); end
    checks++; if (conflict !== 1'b0) begin errors++; $display("FAIL conf_one_cycle got %b exp 0", conflict); end
  endtask

  task automatic test_drop_in_grant();
    logic [7:0] q_exp;
    q_exp = EXP_CONF_Q | 8'h10;
    set_masks(1, 8'h10, 8'h00);
    req = 4'b0010;
    for (int i = 0; i < 20; i++) begin
      if (gnt !== 4'h0) break;
      @(negedge clk);
    end
    checks++; if (gnt !== 4'b0010) begin errors++; $display("FAIL drop_grant got %b exp 0010", gnt); end
    req = 4'b0000;
    @(negedge clk);
    checks++; if (Q !== q_exp || gnt !== 4'b0010) begin errors++; $display("FAIL drop_apply got q=%h gnt=%b exp %h 0010", Q, gnt, q_exp); end
    @(negedge clk);
    checks++; if (gnt !== 4'h0 || busy !== 1'b0) begin errors++; $display("FAIL drop_idle got gnt=%b busy=%b exp 0000 0", gnt, busy); end
    repeat (3) @(negedge clk);
    checks++; if (gnt !== 4'h0 || Q !== q_exp) begin errors++; $display("FAIL drop_no_regrant got gnt=%b q=%h exp 0000 %h", gnt, Q, q_exp); end
  endtask

  task automatic test_reset_mid_hold();
    logic [3:0] g; logic [7:0] qh; logic ch; bit ok;
    set_masks(2, 8'h3C, 8'h00);
    req = 4'b0100;
    for (int i = 0; i < 20; i++) begin
      if (gnt !== 4'h0) break;
      @(negedge clk);
    end
    @(negedge clk);
    checks++; if (busy !== 1'b1 || gnt !== 4'b0100) begin errors++; $display("FAIL midrst_in_hold got busy=%b gnt=%b exp 1 0100", busy, gnt); end
    rst = 1'b1;
    #1;
    checks++; if (Q !== 8'h00 || Qn !== 8'hFF) begin errors++; $display("FAIL midrst_q got %h/%h exp 00/ff", Q, Qn); end
    checks++; if (gnt !== 4'h0 || busy !== 1'b0 || conflict !== 1'b0) begin errors++; $display("FAIL midrst_ctl got gnt=%b busy=%b c=%b exp 0000 0 0", gnt, busy, conflict); end
    req = 4'b0000;
    @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    checks++; if (gnt !== 4'h0 || Q !== 8'h00) begin errors++; $display("FAIL midrst_discard got gnt=%b q=%h exp 0000 00", gnt, Q); end
    // Pointer was cleared: requester 0 beats 3.
    req = 4'b1001;
    serve(g, qh, ch, ok);
    checks++; if (ok !== 1'b1 || g !== 4'b0001) begin errors++; $display("FAIL midrst_ptr got %b exp 0001", g); end
    serve(g, qh, ch, ok);
  endtask

  initial begin
    test_reset();
    test_single();
    test_round_robin();
    test_ptr_wrap();
    test_conflict();
    test_drop_in_grant();
    test_reset_mid_hold();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
